// File: rtl/file_io_req_queue.sv
// Request queue between a node's file I/O detector and the host file-operation engine.
// Edge-triggered capture into a FIFO; one request at a time is served through a 3-state handshake.
module file_io_req_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          in_valid,
  input  logic [31:0]   in_instruction,
  input  logic [31:0]   in_a0,
  input  logic [31:0]   in_a1,
  input  logic [31:0]   in_a2,
  input  logic [31:0]   in_offset,
  output logic          op_complete,
  input  logic          req_ack,
  output logic          host_valid,
  input  logic          host_ready,
  output logic [31:0]   host_instruction,
  output logic [31:0]   host_a0,
  output logic [31:0]   host_a1,
  output logic [31:0]   host_a2,
  output logic [31:0]   host_offset,
  input  logic          host_done,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    COMPLETE
  } state_t;

  state_t         state_q, state_d;
  logic [159:0]   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic [159:0]   svc_q;
  logic [159:0]   host_data;
  logic           in_valid_q;
  logic           overflow_q;
  logic           push, pop, full, push_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign push    = in_valid && !in_valid_q;
  assign pop     = (state_q == IDLE) && (count_q != '0) && host_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      svc_q      <= '0;
      in_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_valid_q <= in_valid;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        svc_q    <= mem_q[rd_ptr_q];
      end
      if (push_ok && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push_ok) begin
        count_q <= count_q - CW'(1);
      end
      if (push && !push_ok) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage carries no reset; entries are only visible through count/pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {in_instruction, in_a0, in_a1, in_a2, in_offset};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (pop)       state_d = WAIT_DONE;
      WAIT_DONE: if (host_done) state_d = COMPLETE;
      COMPLETE:  if (req_ack)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    host_data = svc_q;
    if (state_q == IDLE) begin
      host_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    end
  end

  assign host_valid       = (state_q == IDLE) && (count_q != '0);
  assign host_instruction = host_data[159:128];
  assign host_a0          = host_data[127:96];
  assign host_a1          = host_data[95:64];
  assign host_a2          = host_data[63:32];
  assign host_offset      = host_data[31:0];
  assign op_complete      = (state_q == COMPLETE);
  assign busy             = (state_q != IDLE);
  assign count            = count_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_file_io_req_queue.sv
// Directed plus randomized bench for file_io_req_queue against a queue-based reference model.
module tb_file_io_req_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          res;
  logic          in_valid;
  logic [31:0]   in_instruction, in_a0, in_a1, in_a2, in_offset;
  logic          op_complete;
  logic          req_ack;
  logic          host_valid;
  logic          host_ready;
  logic [31:0]   host_instruction, host_a0, host_a1, host_a2, host_offset;
  logic          host_done;
  logic [CW-1:0] count;
  logic          overflow;
  logic          busy;

  file_io_req_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .res(res), .in_valid(in_valid),
    .in_instruction(in_instruction), .in_a0(in_a0), .in_a1(in_a1), .in_a2(in_a2),
    .in_offset(in_offset), .op_complete(op_complete), .req_ack(req_ack),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_instruction(host_instruction), .host_a0(host_a0), .host_a1(host_a1),
    .host_a2(host_a2), .host_offset(host_offset), .host_done(host_done),
    .count(count), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef logic [159:0] ent_t;

  // Reference model: pending requests, phase 0=idle 1=host working 2=waiting for ack.
  ent_t mq[$];
  int   phase;
  ent_t svc;
  bit   prev_valid;
  bit   ovf;

  int total = 0;
  int bad   = 0;

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit hv;
    if (res) begin
      mq.delete();
      phase      = 0;
      svc        = '0;
      prev_valid = 0;
      ovf        = 0;
    end else begin
      hv = (phase == 0) && (mq.size() > 0);
      if (hv && host_ready) begin
        svc   = mq.pop_front();
        phase = 1;
      end else if (phase == 1 && host_done) begin
        phase = 2;
      end else if (phase == 2 && req_ack) begin
        phase = 0;
      end
      if (in_valid && !prev_valid) begin
        if (mq.size() < DEPTH) mq.push_back({in_instruction, in_a0, in_a1, in_a2, in_offset});
        else ovf = 1;
      end
      prev_valid = in_valid;
    end
  endtask

  task automatic check_all();
    ent_t e;
    e = (phase != 0) ? svc : ((mq.size() > 0) ? mq[0] : '0);
    cmp("host_valid", 32'(host_valid), 32'((phase == 0) && (mq.size() > 0)));
    cmp("op_complete", 32'(op_complete), 32'(phase == 2));
    cmp("busy", 32'(busy), 32'(phase != 0));
    cmp("count", 32'(count), 32'(mq.size()));
    cmp("overflow", 32'(overflow), 32'(ovf));
    cmp("host_instruction", host_instruction, e[159:128]);
    cmp("host_a0", host_a0, e[127:96]);
    cmp("host_a1", host_a1, e[95:64]);
    cmp("host_a2", host_a2, e[63:32]);
    cmp("host_offset", host_offset, e[31:0]);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_req(input logic [31:0] i, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] off);
    in_instruction = i; in_a0 = a0; in_a1 = a1; in_a2 = a2; in_offset = off;
  endtask

  task automatic pulse(input logic [31:0] i);
    set_req(i, i + 32'h10, i + 32'h20, i + 32'h30, i + 32'h4000);
    in_valid = 1; tick();
    in_valid = 0; tick();
  endtask

  task automatic do_reset();
    res = 1; tick();
    res = 0;
  endtask

  task automatic serve_one(input logic [31:0] exp_instr);
    cmp("serve_head", host_instruction, exp_instr);
    host_ready = 1; tick();
    host_ready = 0; host_done = 1; tick();
    host_done = 0; req_ack = 1; tick();
    req_ack = 0;
  endtask

  initial begin
    res = 1; in_valid = 0; req_ack = 0; host_ready = 0; host_done = 0;
    set_req('0, '0, '0, '0, '0);
    phase = 0; svc = '0; prev_valid = 0; ovf = 0;
    tick(); tick();
    res = 0;
    cmp("reset_count", 32'(count), 32'd0);
    cmp("reset_busy", 32'(busy), 32'd0);

    // Single request
    host_ready = 1;
    set_req(32'h1, 32'h10, 32'h20, 32'h30, 32'h4000);
    in_valid = 1; tick();
    in_valid = 0;
    cmp("single_hv", 32'(host_valid), 32'd1);
    cmp("single_off", host_offset, 32'h4000);
    tick();
    cmp("single_hv_drop", 32'(host_valid), 32'd0);
    host_ready = 0; host_done = 1; tick();
    host_done = 0;
    cmp("single_opc", 32'(op_complete), 32'd1);
    tick();
    req_ack = 1; tick();
    req_ack = 0;
    cmp("single_release", 32'(op_complete), 32'd0);

    // Level hold gives one push
    set_req(32'h2, 32'h3, 32'h4, 32'h5, 32'h6);
    in_valid = 1;
    for (int i = 0; i < 10; i++) tick();
    in_valid = 0; tick();
    cmp("level_count", 32'(count), 32'd1);
    serve_one(32'h2);

    // Fill and overflow
    for (int i = 0; i < 5; i++) pulse(32'h100 + 32'(i));
    cmp("fill_count", 32'(count), 32'd4);
    cmp("fill_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) serve_one(32'h100 + 32'(i));
    tick();
    cmp("drain_count", 32'(count), 32'd0);
    cmp("drain_hv", 32'(host_valid), 32'd0);
    do_reset();

    // Push into full FIFO concurrent with pop
    for (int i = 0; i < 4; i++) pulse(32'h200 + 32'(i));
    set_req(32'h2FF, 32'h1, 32'h2, 32'h3, 32'h4);
    in_valid = 1; host_ready = 1; tick();
    in_valid = 0; host_ready = 0;
    cmp("sim_count", 32'(count), 32'd4);
    cmp("sim_ovf", 32'(overflow), 32'd0);
    host_done = 1; tick();
    host_done = 0; req_ack = 1; tick();
    req_ack = 0;
    for (int i = 1; i < 4; i++) serve_one(32'h200 + 32'(i));
    serve_one(32'h2FF);
    do_reset();

    // Back-to-back service; host_done in IDLE ignored
    for (int i = 0; i < 3; i++) pulse(32'h300 + 32'(i));
    host_done = 1; tick();
    cmp("idle_done_busy", 32'(busy), 32'd0);
    host_done = 0;
    host_ready = 1; tick();
    host_done = 1; req_ack = 1;
    for (int i = 0; i < 8; i++) tick();
    host_ready = 0; host_done = 0; req_ack = 0;
    tick();
    cmp("b2b_count", 32'(count), 32'd0);
    cmp("b2b_busy", 32'(busy), 32'd0);

    // Reset while in COMPLETE with two pending
    for (int i = 0; i < 3; i++) pulse(32'h400 + 32'(i));
    host_ready = 1; tick();
    host_ready = 0; host_done = 1; tick();
    host_done = 0;
    cmp("mid_opc", 32'(op_complete), 32'd1);
    cmp("mid_count", 32'(count), 32'd2);
    do_reset();
    cmp("mid_rst_opc", 32'(op_complete), 32'd0);
    cmp("mid_rst_count", 32'(count), 32'd0);
    cmp("mid_rst_hv", 32'(host_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      res        = ($urandom_range(0, 99) == 0);
      in_valid   = ($urandom_range(0, 2) == 0);
      host_ready = ($urandom_range(0, 3) != 0);
      host_done  = ($urandom_range(0, 2) == 0);
      req_ack    = ($urandom_range(0, 2) == 0);
      set_req($urandom, $urandom, $urandom, $urandom, $urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
